// File: rtl/modulo_unit.sv
`default_nettype none
// ============================================================================
// Module   : modulo_unit
// Purpose  : Sequential restoring divider. Produces a mod b and a / b, one
//            quotient bit per clock, behind a level start/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module modulo_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             modulo_start_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             modulo_ready_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic             div_by_zero_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a_w;
    logic [WIDTH-1:0]   r_b_w;
    logic [WIDTH-1:0]   r_rem_w;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_ready;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_dbz;
    logic               r_busy;

    logic [WIDTH:0]     w_t;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_a_next;
    logic               w_last;

    // The compare is one bit wider than the operands so the shifted partial
    // remainder cannot overflow; the difference itself always fits in WIDTH.
    assign w_t        = {r_rem_w, r_a_w[WIDTH-1]};
    assign w_ge       = (w_t >= {1'b0, r_b_w});
    assign w_sub      = w_t[WIDTH-1:0] - r_b_w;
    assign w_rem_next = w_ge ? w_sub : w_t[WIDTH-1:0];
    assign w_a_next   = {r_a_w[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (modulo_start_i) begin
                    w_next_state = (operand_b_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (!modulo_start_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_w   <= '0;
            r_b_w   <= '0;
            r_rem_w <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (modulo_start_i) begin
                        r_a_w   <= operand_a_i;
                        r_b_w   <= operand_b_i;
                        r_rem_w <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        if (operand_b_i == '0) begin
                            r_rem   <= operand_a_i;
                            r_quo   <= '1;
                            r_dbz   <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_a_w   <= w_a_next;
                    r_rem_w <= w_rem_next;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_rem   <= w_rem_next;
                        r_quo   <= w_a_next;
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                DONE: begin
                    // Ready holds until start is seen low, so a held start never re-triggers.
                    if (!modulo_start_i) begin
                        r_ready <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign modulo_ready_o = r_ready;
    assign remainder_o    = r_rem;
    assign quotient_o     = r_quo;
    assign div_by_zero_o  = r_dbz;
    assign busy_o         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_modulo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_unit
// Purpose  : Directed self-checking bench for modulo_unit (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             modulo_start_i;
    logic [WIDTH-1:0] operand_a_i;
    logic [WIDTH-1:0] operand_b_i;
    logic             modulo_ready_o;
    logic [WIDTH-1:0] remainder_o;
    logic [WIDTH-1:0] quotient_o;
    logic             div_by_zero_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;

    modulo_unit #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .modulo_start_i (modulo_start_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .modulo_ready_o (modulo_ready_o),
        .remainder_o    (remainder_o),
        .quotient_o     (quotient_o),
        .div_by_zero_o  (div_by_zero_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_results(input string tag, input logic [7:0] er, input logic [7:0] eq,
                                 input logic edbz);
        check({tag, " rem"}, 32'(remainder_o), 32'(er));
        check({tag, " quo"}, 32'(quotient_o), 32'(eq));
        check({tag, " dbz"}, 32'(div_by_zero_o), 32'(edbz));
    endtask

    // Raise start, count edges until ready (bounded), verify results, then release.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [7:0] eq, input logic edbz,
                         input int elat);
        int n;
        operand_a_i    = a;
        operand_b_i    = b;
        modulo_start_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!modulo_ready_o && n < 40);
        check({tag, " latency"}, 32'(n), 32'(elat));
        check_results(tag, er, eq, edbz);
        check({tag, " busy_done"}, 32'(busy_o), 32'(0));
        modulo_start_i = 1'b0;
        tick();
        check({tag, " ready_drop"}, 32'(modulo_ready_o), 32'(0));
    endtask

    initial begin
        rst            = 1'b1;
        modulo_start_i = 1'b0;
        operand_a_i    = '0;
        operand_b_i    = '0;
        tick();
        tick();
        check("reset ready", 32'(modulo_ready_o), 32'(0));
        check("reset busy", 32'(busy_o), 32'(0));
        check_results("reset", 8'd0, 8'd0, 1'b0);
        rst = 1'b0;
        tick();

        // 48 mod 18: busy for exactly 8 cycles, ready after edge 9.
        operand_a_i    = 8'd48;
        operand_b_i    = 8'd18;
        modulo_start_i = 1'b1;
        tick();
        check("t1 busy e1", 32'(busy_o), 32'(1));
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("t1 busy mid", 32'(busy_o), 32'(1));
            check("t1 ready mid", 32'(modulo_ready_o), 32'(0));
        end
        tick();
        check("t1 ready e9", 32'(modulo_ready_o), 32'(1));
        check("t1 busy e9", 32'(busy_o), 32'(0));
        check_results("t1", 8'd12, 8'd2, 1'b0);
        tick();
        check("t1 ready held", 32'(modulo_ready_o), 32'(1));
        modulo_start_i = 1'b0;
        tick();
        check("t1 ready drop", 32'(modulo_ready_o), 32'(0));
        check_results("t1 idle", 8'd12, 8'd2, 1'b0);

        do_op("t2", 8'd5,   8'd9, 8'd5, 8'd0,   1'b0, 9);
        do_op("t3", 8'd255, 8'd1, 8'd0, 8'd255, 1'b0, 9);
        do_op("t4", 8'd37,  8'd0, 8'd37, 8'hFF, 1'b1, 1);
        do_op("t5", 8'd10,  8'd3, 8'd1, 8'd3,   1'b0, 9);
        do_op("t6", 8'd255, 8'd255, 8'd0, 8'd1, 1'b0, 9);
        do_op("t7", 8'd0,   8'd5, 8'd0, 8'd0,   1'b0, 9);
        do_op("t8", 8'd254, 8'd255, 8'd254, 8'd0, 1'b0, 9);

        // Held start with operands disturbed during CALC and DONE: 200 = 13*15 + 5.
        operand_a_i    = 8'd200;
        operand_b_i    = 8'd13;
        modulo_start_i = 1'b1;
        tick();
        operand_a_i = 8'd7;
        operand_b_i = 8'd0;
        for (int i = 2; i <= 9; i++) tick();
        check("hold ready", 32'(modulo_ready_o), 32'(1));
        check_results("hold", 8'd5, 8'd15, 1'b0);
        for (int i = 0; i < 5; i++) begin
            operand_a_i = 8'(i * 31 + 3);
            operand_b_i = 8'(i + 2);
            tick();
            check("hold ready kept", 32'(modulo_ready_o), 32'(1));
            check("hold busy", 32'(busy_o), 32'(0));
            check_results("hold kept", 8'd5, 8'd15, 1'b0);
        end
        modulo_start_i = 1'b0;
        tick();
        check("hold ready drop", 32'(modulo_ready_o), 32'(0));
        tick();
        tick();
        check("hold idle busy", 32'(busy_o), 32'(0));
        check_results("hold idle", 8'd5, 8'd15, 1'b0);

        // Reset on the 4th CALC edge (edge 5) discards the operation.
        operand_a_i    = 8'd100;
        operand_b_i    = 8'd7;
        modulo_start_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst ready", 32'(modulo_ready_o), 32'(0));
        check("midrst busy", 32'(busy_o), 32'(0));
        check_results("midrst", 8'd0, 8'd0, 1'b0);
        rst = 1'b0;
        do_op("after_rst", 8'd100, 8'd7, 8'd2, 8'd14, 1'b0, 9);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            do_op("sweep", a, b, a % b, a / b, 1'b0, 9);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
